uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 78 +++++++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: data width, receiver state
// encoding, the layout of one received-frame FIFO entry, and the parity
// helper (bit-exact with the transmitter).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_DATA   = 3'd1,
    RX_PARITY = 3'd2,
    RX_STOP   = 3'd3,
    RX_BREAK  = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic                   frame_err;
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } rx_frame_t;

  localparam int RX_FRAME_W = $bits(rx_frame_t);

  // The "even" select inverts the XOR reduction; this matches uart_tx exactly,
  // whatever the name suggests.
  function automatic logic expected_parity(input logic [UART_DATA_W-1:0] data,
                                           input logic                   even);
    return even ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO holding completed receive frames. Head entry is presented
// combinationally from storage; no write-to-read bypass, so a push into an
// empty FIFO becomes visible the cycle after the push edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (empties FIFO, clears storage)
//   i_push     write i_data this edge (dropped if full and not popping)
//   i_data     entry to write
//   i_pop      consumer accepts head (ignored while empty)
//   o_valid    FIFO holds at least one entry
//   o_data     head entry
//   o_overrun  one-cycle pulse after an edge where a push was dropped
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overrun;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_valid   = (r_count != '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_overrun = r_overrun;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = i_pop & o_valid;
  // When full, a same-edge pop frees the head slot, which is exactly the slot
  // the write pointer addresses, so the push can still be taken.
  assign w_push_ok = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_overrun <= i_push & w_full & ~w_pop;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// One-sample-per-bit UART receiver for a same-clock-domain uart_tx link.
// Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
// Completed frames (with parity/framing error flags) are queued in
// uart_rx_fifo and offered on a valid/ready interface.
//
// State table
//   state  | meaning
//   IDLE   | line idle, waiting for a 0 (start bit); latches parity config
//   DATA   | shifting in 8 data bits, bit 0 first
//   PARITY | sampling parity bit, recording mismatch
//   STOP   | sampling stop bit, pushing frame; 0 here means break/framing err
//   BREAK  | line held low after a bad stop; wait for 1 before re-arming
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   rx                    serial line (idle high)
//   parity_en, even_parity  frame config, latched at start-bit detection
//   m_valid/m_ready       head-of-FIFO handshake
//   m_data, m_parity_err, m_frame_err  head frame fields
//   overrun               pulse when a completed frame was dropped (FIFO full)
//   rx_busy               receiver not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   parity_en,
  input  logic                   even_parity,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [UART_DATA_W-1:0] m_data,
  output logic                   m_parity_err,
  output logic                   m_frame_err,
  output logic                   overrun,
  output logic                   rx_busy
);

  localparam logic [2:0] ST_IDLE   = RX_IDLE;
  localparam logic [2:0] ST_DATA   = RX_DATA;
  localparam logic [2:0] ST_PARITY = RX_PARITY;
  localparam logic [2:0] ST_STOP   = RX_STOP;
  localparam logic [2:0] ST_BREAK  = RX_BREAK;

  logic [2:0]             r_state;
  logic [UART_DATA_W-1:0] r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_par_en;
  logic                   r_even;
  logic                   r_parity_err;

  logic      w_push;
  rx_frame_t w_frame;
  rx_frame_t w_head;
  logic      w_head_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_en     <= 1'b0;
      r_even       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!rx) begin
            r_state      <= ST_DATA;
            r_par_en     <= parity_en;
            r_even       <= even_parity;
            r_bit_cnt    <= '0;
            r_parity_err <= 1'b0;
          end
        end
        ST_DATA: begin
          r_shift   <= {rx, r_shift[UART_DATA_W-1:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= r_par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          r_parity_err <= (rx != expected_parity(r_shift, r_even));
          r_state      <= ST_STOP;
        end
        ST_STOP: begin
          r_state <= rx ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame is pushed on the edge that samples the stop bit; the stop sample
  // itself becomes the framing-error flag.
  assign w_push             = (r_state == ST_STOP);
  assign w_frame.frame_err  = ~rx;
  assign w_frame.parity_err = r_parity_err;
  assign w_frame.data       = r_shift;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RX_FRAME_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (w_frame),
    .i_pop     (m_ready),
    .o_valid   (w_head_valid),
    .o_data    (w_head),
    .o_overrun (overrun)
  );

  assign m_valid      = w_head_valid;
  assign m_data       = w_head.data;
  assign m_parity_err = w_head.parity_err;
  assign m_frame_err  = w_head.frame_err;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. The rx line is driven one bit per clock as
// uart_tx would; inputs change and outputs are sampled 1 ns after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       parity_en;
  logic       even_parity;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_parity_err;
  logic       m_frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .parity_en    (parity_en),
    .even_parity  (even_parity),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_frame_err  (m_frame_err),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  task automatic drive_bit(input logic b);
    rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  // Sends one frame. Parity config is flipped right after the start edge so
  // the receiver must be using its latched copy. rx is left at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ev,
                            input logic par_inv, input logic stop_b,
                            input logic pop_at_stop);
    logic p;
    parity_en   = pen;
    even_parity = ev;
    drive_bit(1'b0);
    parity_en   = ~pen;
    even_parity = ~ev;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) begin
      p = ev ? ~^d : ^d;
      drive_bit(p ^ par_inv);
    end
    if (pop_at_stop) m_ready = 1'b1;
    drive_bit(stop_b);
    m_ready     = 1'b0;
    parity_en   = pen;
    even_parity = ev;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; m_ready = 1'b0; parity_en = 1'b0; even_parity = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    n_checks++; if (m_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", m_parity_err); end
    n_checks++; if (m_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", m_frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    rst_n = 1'b1;
    drive_bit(1'b1);
  endtask

  // 0xA5, no parity. Counting the start-bit cycle as cycle 1, m_valid must be
  // low through cycle 10 (stop bit) and high in cycle 11.
  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    parity_en = 1'b0;
    drive_bit(1'b0);
    parity_en = 1'b1;
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", rx_busy); end
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", m_valid); end
    drive_bit(1'b1);
    parity_en = 1'b0;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", m_valid); end
    n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", m_data); end
    n_checks++; if ({m_frame_err, m_parity_err} !== 2'b00) begin n_fail++; $display("FAIL basic_errs: got %b expected 00", {m_frame_err, m_parity_err}); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", rx_busy); end
    repeat (2) drive_bit(1'b1);
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got valid=%b data=%h expected 1 a5", m_valid, m_data); end
    do_pop();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got %b expected 0", m_valid); end
  endtask

  task automatic test_parity_b2b();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b1);
    n_checks++; if (m_data !== 8'h00 || m_parity_err !== 1'b0 || m_frame_err !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got data=%h perr=%b ferr=%b expected 00 0 0", m_data, m_parity_err, m_frame_err); end
    do_pop();
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hFF || m_parity_err !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got valid=%b data=%h perr=%b expected 1 ff 0", m_valid, m_data, m_parity_err); end
    do_pop();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", m_valid); end
  endtask

  task automatic test_parity_err();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (m_data !== 8'h3C) begin n_fail++; $display("FAIL perr_data: got %h expected 3c", m_data); end
    n_checks++; if (m_parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b expected 1", m_parity_err); end
    n_checks++; if (m_frame_err !== 1'b0) begin n_fail++; $display("FAIL perr_ferr: got %b expected 0", m_frame_err); end
    do_pop();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (m_data !== 8'h07 || m_parity_err !== 1'b0) begin n_fail++; $display("FAIL perr_good: got data=%h perr=%b expected 07 0", m_data, m_parity_err); end
    do_pop();
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin n_fail++; $display("FAIL ferr_data: got valid=%b data=%h expected 1 55", m_valid, m_data); end
    n_checks++; if (m_frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b expected 1", m_frame_err); end
    repeat (5) drive_bit(1'b0);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b expected 1", rx_busy); end
    drive_bit(1'b1);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit: got %b expected 0", rx_busy); end
    do_pop();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_spurious: got valid=%b expected 0", m_valid); end
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (m_data !== 8'h12 || m_frame_err !== 1'b0 || m_parity_err !== 1'b0) begin n_fail++; $display("FAIL ferr_next: got data=%h ferr=%b perr=%b expected 12 0 0", m_data, m_frame_err, m_parity_err); end
    do_pop();
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (overrun !== (i == 5)) begin n_fail++; $display("FAIL ovr_pulse_%0d: got %b expected %b", i, overrun, (i == 5)); end
      drive_bit(1'b1);
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_%0d: got %b expected 0", i, overrun); end
    end
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      n_checks++; if (m_valid !== 1'b1 || m_data !== d) begin n_fail++; $display("FAIL ovr_drain_%0d: got valid=%b data=%h expected 1 %h", i, m_valid, m_data, d); end
      do_pop();
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %b expected 0", m_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    send_frame(8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun: got %b expected 0", overrun); end
    for (int i = 1; i <= 4; i++) begin
      d = 8'h10 + 8'(i);
      n_checks++; if (m_valid !== 1'b1 || m_data !== d) begin n_fail++; $display("FAIL fpp_drain_%0d: got valid=%b data=%h expected 1 %h", i, m_valid, m_data, d); end
      do_pop();
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b expected 0", m_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rst_n = 1'b0;
    drive_bit(1'b1);
    n_checks++; if (rx_busy !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_reset: got busy=%b valid=%b expected 0 0", rx_busy, m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rmf_data_clr: got %h expected 00", m_data); end
    rst_n = 1'b1;
    repeat (12) drive_bit(1'b1);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_no_push: got %b expected 0", m_valid); end
    send_frame(8'h9A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h9A || m_frame_err !== 1'b0) begin n_fail++; $display("FAIL rmf_next: got valid=%b data=%h ferr=%b expected 1 9a 0", m_valid, m_data, m_frame_err); end
    do_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity_b2b();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_full_push_pop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
